// File: rtl/sad_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : sad_scheduler
//  Purpose  : Column FIFO + issue FSM feeding the stereo SAD engine, and a
//             result collector that masks warm-up columns and flags frame end.
//  Revision : 1.0  initial release
// ============================================================================
module sad_scheduler #(
  parameter int KERNEL_WIDTH = 3,
  parameter int OFFSET       = 10,
  parameter int FIFO_DEPTH   = 4,
  parameter int H_ACTIVE     = 320,
  parameter int V_ACTIVE     = 240
) (
  input  logic                      clk_in,
  input  logic                      rst_n_in,
  input  logic                      col_valid_in,
  output logic                      col_ready_out,
  input  logic [KERNEL_WIDTH*8-1:0] left_col_in,
  input  logic [KERNEL_WIDTH*8-1:0] right_col_in,
  input  logic [9:0]                hcount_in,
  input  logic [8:0]                vcount_in,
  output logic                      sad_valid_out,
  output logic [KERNEL_WIDTH*8-1:0] sad_left_out,
  output logic [KERNEL_WIDTH*8-1:0] sad_right_out,
  output logic [9:0]                sad_hcount_out,
  output logic [8:0]                sad_vcount_out,
  input  logic                      sad_busy_in,
  input  logic                      sad_valid_in,
  input  logic [9:0]                sad_hcount_in,
  input  logic [8:0]                sad_vcount_in,
  input  logic [7:0]                sad_depth_in,
  output logic                      depth_valid_out,
  output logic [9:0]                depth_hcount_out,
  output logic [8:0]                depth_vcount_out,
  output logic [7:0]                depth_out,
  output logic                      frame_done_out,
  output logic [15:0]               drop_count_out,
  output logic                      stall_err_out
);

  localparam int DW = KERNEL_WIDTH * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;
  localparam int TW = $clog2(OFFSET + 5);

  localparam logic [TW-1:0] STALL_LIMIT = TW'(OFFSET + 4);
  localparam logic [9:0]    WARM_LIMIT  = 10'(KERNEL_WIDTH + OFFSET - 1);
  localparam logic [9:0]    H_LAST      = 10'(H_ACTIVE - 1);
  localparam logic [8:0]    V_LAST      = 9'(V_ACTIVE - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    ARM   = 2'd2,
    WAIT  = 2'd3
  } state_t;

  state_t        state;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [TW-1:0] timer;

  logic [DW-1:0] mem_left  [FIFO_DEPTH];
  logic [DW-1:0] mem_right [FIFO_DEPTH];
  logic [9:0]    mem_h     [FIFO_DEPTH];
  logic [8:0]    mem_v     [FIFO_DEPTH];

  logic full;
  logic empty;
  logic push;
  logic pop;

  // Extra pointer MSB distinguishes full from empty when the indices match
  assign full          = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty         = (wr_ptr == rd_ptr);
  assign col_ready_out = !full;
  assign push          = col_valid_in && !full;
  assign pop           = (state == IDLE) && !empty && !sad_busy_in;

  // Column storage; contents are don't-care until written, so no reset
  always_ff @(posedge clk_in) begin
    if (push) begin
      mem_left[wr_ptr[AW-1:0]]  <= left_col_in;
      mem_right[wr_ptr[AW-1:0]] <= right_col_in;
      mem_h[wr_ptr[AW-1:0]]     <= hcount_in;
      mem_v[wr_ptr[AW-1:0]]     <= vcount_in;
    end
  end

  // Write pointer and saturating drop counter (ready ignores a same-cycle pop)
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      wr_ptr         <= '0;
      drop_count_out <= '0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + PW'(1);
      if (col_valid_in && full && (drop_count_out != 16'hFFFF))
        drop_count_out <= drop_count_out + 16'd1;
    end
  end

  // Issue FSM: pop into output registers, strobe once, then wait out busy
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      state          <= IDLE;
      rd_ptr         <= '0;
      timer          <= '0;
      sad_valid_out  <= 1'b0;
      sad_left_out   <= '0;
      sad_right_out  <= '0;
      sad_hcount_out <= '0;
      sad_vcount_out <= '0;
      stall_err_out  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pop) begin
            sad_left_out   <= mem_left[rd_ptr[AW-1:0]];
            sad_right_out  <= mem_right[rd_ptr[AW-1:0]];
            sad_hcount_out <= mem_h[rd_ptr[AW-1:0]];
            sad_vcount_out <= mem_v[rd_ptr[AW-1:0]];
            rd_ptr         <= rd_ptr + PW'(1);
            sad_valid_out  <= 1'b1;
            state          <= ISSUE;
          end
        end
        ISSUE: begin
          sad_valid_out <= 1'b0;
          state         <= ARM;
        end
        ARM: begin
          // Engine busy is not yet visible here; start the timeout from zero
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (!sad_busy_in) begin
            state <= IDLE;
          end else begin
            timer <= timer + TW'(1);
            if (timer + TW'(1) == STALL_LIMIT) begin
              stall_err_out <= 1'b1;
              state         <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Result collector: one-cycle register stage, warm-up masking, frame end
  always_ff @(posedge clk_in) begin
    if (!rst_n_in) begin
      depth_valid_out  <= 1'b0;
      depth_hcount_out <= '0;
      depth_vcount_out <= '0;
      depth_out        <= '0;
      frame_done_out   <= 1'b0;
    end else begin
      depth_valid_out <= sad_valid_in;
      frame_done_out  <= sad_valid_in && (sad_hcount_in == H_LAST) && (sad_vcount_in == V_LAST);
      if (sad_valid_in) begin
        depth_hcount_out <= sad_hcount_in;
        depth_vcount_out <= sad_vcount_in;
        depth_out        <= (sad_hcount_in < WARM_LIMIT) ? 8'd0 : sad_depth_in;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sad_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_sad_scheduler
//  Purpose  : Self-checking bench for sad_scheduler (vector table + sequences)
//  Revision : 1.0  initial release
// ============================================================================
module tb_sad_scheduler;

  localparam int KW = 3;
  localparam int DW = KW * 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          col_valid = 1'b0;
  logic          col_ready;
  logic [DW-1:0] left_col = '0;
  logic [DW-1:0] right_col = '0;
  logic [9:0]    hcount = '0;
  logic [8:0]    vcount = '0;
  logic          sad_valid;
  logic [DW-1:0] sad_left;
  logic [DW-1:0] sad_right;
  logic [9:0]    sad_hcount;
  logic [8:0]    sad_vcount;
  logic          sad_busy;
  logic          res_valid = 1'b0;
  logic [9:0]    res_h = '0;
  logic [8:0]    res_v = '0;
  logic [7:0]    res_depth = '0;
  logic          depth_valid;
  logic [9:0]    depth_h;
  logic [8:0]    depth_v;
  logic [7:0]    depth;
  logic          frame_done;
  logic [15:0]   drop_count;
  logic          stall_err;

  int total = 0;
  int passed = 0;

  // Engine model: busy for busy_len cycles after each issue, or stuck high
  int busy_len = 11;
  int busy_cnt = 0;
  logic stuck = 1'b0;
  assign sad_busy = stuck || (busy_cnt > 0);

  typedef struct {
    logic [DW-1:0] l;
    logic [DW-1:0] r;
    logic [9:0]    h;
    logic [8:0]    v;
  } issue_t;
  issue_t issued[$];

  sad_scheduler #(
    .KERNEL_WIDTH(3), .OFFSET(10), .FIFO_DEPTH(4), .H_ACTIVE(320), .V_ACTIVE(240)
  ) dut (
    .clk_in(clk), .rst_n_in(rst_n),
    .col_valid_in(col_valid), .col_ready_out(col_ready),
    .left_col_in(left_col), .right_col_in(right_col),
    .hcount_in(hcount), .vcount_in(vcount),
    .sad_valid_out(sad_valid), .sad_left_out(sad_left), .sad_right_out(sad_right),
    .sad_hcount_out(sad_hcount), .sad_vcount_out(sad_vcount),
    .sad_busy_in(sad_busy),
    .sad_valid_in(res_valid), .sad_hcount_in(res_h), .sad_vcount_in(res_v),
    .sad_depth_in(res_depth),
    .depth_valid_out(depth_valid), .depth_hcount_out(depth_h),
    .depth_vcount_out(depth_v), .depth_out(depth),
    .frame_done_out(frame_done), .drop_count_out(drop_count),
    .stall_err_out(stall_err)
  );

  always #5 clk = ~clk;

  // Engine busy countdown and issue monitor, both on the falling edge
  always @(negedge clk) begin
    if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    if (sad_valid) begin
      busy_cnt = busy_len;
      issued.push_back('{sad_left, sad_right, sad_hcount, sad_vcount});
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic push_col(input logic [9:0] h, input logic [8:0] v);
    col_valid = 1'b1;
    hcount    = h;
    vcount    = v;
    left_col  = {8'(h), 8'(v), 8'hA5};
    right_col = {8'(v), 8'(h), 8'h5A};
    @(negedge clk);
    col_valid = 1'b0;
  endtask

  // Waits on the falling edge for an issue strobe; counts a timeout as a failure
  task automatic wait_issue(input int limit, output bit seen);
    seen = 1'b0;
    for (int i = 0; i < limit && !seen; i++) begin
      @(negedge clk);
      if (sad_valid) seen = 1'b1;
    end
    if (!seen) begin
      total++;
      $display("FAIL issue_timeout: got no strobe expected strobe within %0d", limit);
    end
  endtask

  typedef struct {
    logic [9:0] h;
    logic [8:0] v;
    logic [7:0] d;
    logic [7:0] exp_d;
    logic       exp_fd;
  } vec_t;

  initial begin
    vec_t vt[9];
    bit   seen;
    int   k;

    vt[0] = '{10'd0,   9'd3,   8'd200, 8'd0,   1'b0};
    vt[1] = '{10'd5,   9'd3,   8'd200, 8'd0,   1'b0};
    vt[2] = '{10'd11,  9'd3,   8'd200, 8'd0,   1'b0};
    vt[3] = '{10'd12,  9'd3,   8'd200, 8'd200, 1'b0};
    vt[4] = '{10'd20,  9'd5,   8'd127, 8'd127, 1'b0};
    vt[5] = '{10'd319, 9'd239, 8'd90,  8'd90,  1'b1};
    vt[6] = '{10'd319, 9'd238, 8'd91,  8'd91,  1'b0};
    vt[7] = '{10'd0,   9'd239, 8'd92,  8'd0,   1'b0};
    vt[8] = '{10'd318, 9'd239, 8'd55,  8'd55,  1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_ready", 32'(col_ready), 32'd1);
    chk("rst_sad_valid", 32'(sad_valid), 32'd0);
    chk("rst_sad_h", 32'(sad_hcount), 32'd0);
    chk("rst_depth_valid", 32'(depth_valid), 32'd0);
    chk("rst_drop", 32'(drop_count), 32'd0);
    chk("rst_stall", 32'(stall_err), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Single column: issue strobe two edges after acceptance, exactly once
    issued.delete();
    push_col(10'd20, 9'd5);
    chk("issue_lat_early", 32'(sad_valid), 32'd0);
    @(negedge clk);
    chk("issue_lat", 32'(sad_valid), 32'd1);
    @(negedge clk);
    chk("issue_one_cycle", 32'(sad_valid), 32'd0);
    repeat (20) @(negedge clk);
    chk("single_count", 32'(issued.size()), 32'd1);
    if (issued.size() >= 1) begin
      chk("single_h", 32'(issued[0].h), 32'd20);
      chk("single_v", 32'(issued[0].v), 32'd5);
      chk("single_left", 32'(issued[0].l), {8'h0, 8'd20, 8'd5, 8'hA5});
      chk("single_right", 32'(issued[0].r), {8'h0, 8'd5, 8'd20, 8'h5A});
    end

    // Collector vectors: warm-up mask, pass-through, frame-done boundary
    for (int i = 0; i < 9; i++) begin
      res_valid = 1'b1;
      res_h     = vt[i].h;
      res_v     = vt[i].v;
      res_depth = vt[i].d;
      @(negedge clk);
      res_valid = 1'b0;
      chk($sformatf("vec%0d_valid", i), 32'(depth_valid), 32'd1);
      chk($sformatf("vec%0d_depth", i), 32'(depth), 32'(vt[i].exp_d));
      chk($sformatf("vec%0d_h", i), 32'(depth_h), 32'(vt[i].h));
      chk($sformatf("vec%0d_v", i), 32'(depth_v), 32'(vt[i].v));
      chk($sformatf("vec%0d_frame", i), 32'(frame_done), 32'(vt[i].exp_fd));
    end
    @(negedge clk);
    chk("depth_valid_drop", 32'(depth_valid), 32'd0);

    // Burst of 6 while engine busy: 4 stored, 2 dropped, then in-order issue
    issued.delete();
    stuck = 1'b1;
    busy_len = 6;
    @(negedge clk);
    for (int i = 0; i < 6; i++) begin
      if (i == 4) chk("burst_ready_low", 32'(col_ready), 32'd0);
      if (i == 3) chk("burst_ready_high", 32'(col_ready), 32'd1);
      push_col(10'(100 + i), 9'd7);
      col_valid = (i < 5);
    end
    col_valid = 1'b0;
    chk("burst_drops", 32'(drop_count), 32'd2);
    chk("burst_no_issue", 32'(issued.size()), 32'd0);
    stuck = 1'b0;
    repeat (60) @(negedge clk);
    chk("burst_count", 32'(issued.size()), 32'd4);
    for (int i = 0; i < 4 && i < issued.size(); i++)
      chk($sformatf("burst_order%0d", i), 32'(issued[i].h), 32'(100 + i));
    chk("burst_ready_back", 32'(col_ready), 32'd1);
    chk("no_stall_yet", 32'(stall_err), 32'd0);

    // Stuck busy: stall flagged OFFSET+4 WAIT cycles after ARM
    issued.delete();
    busy_len = 0;
    push_col(10'd50, 9'd8);
    wait_issue(10, seen);
    if (seen) begin
      stuck = 1'b1;
      k = 0;
      while (!stall_err && k < 40) begin
        @(negedge clk);
        k++;
      end
      chk("stall_delay", 32'(k), 32'd16);
      push_col(10'd51, 9'd8);
      repeat (5) @(negedge clk);
      chk("stall_hold_issue", 32'(issued.size()), 32'd1);
      busy_len = 3;
      stuck = 1'b0;
      wait_issue(10, seen);
      if (seen) chk("after_stall_h", 32'(sad_hcount), 32'd51);
      chk("stall_sticky", 32'(stall_err), 32'd1);
    end

    // Reset during WAIT with a column still queued
    stuck = 1'b1;
    repeat (10) @(negedge clk);
    issued.delete();
    stuck = 1'b0;
    push_col(10'd60, 9'd9);
    push_col(10'd61, 9'd9);
    stuck = 1'b1;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("mid_rst_ready", 32'(col_ready), 32'd1);
    chk("mid_rst_sad_valid", 32'(sad_valid), 32'd0);
    chk("mid_rst_sad_h", 32'(sad_hcount), 32'd0);
    chk("mid_rst_depth", 32'(depth), 32'd0);
    chk("mid_rst_depth_h", 32'(depth_h), 32'd0);
    chk("mid_rst_drop", 32'(drop_count), 32'd0);
    chk("mid_rst_stall", 32'(stall_err), 32'd0);
    rst_n = 1'b1;
    stuck = 1'b0;
    busy_cnt = 0;
    issued.delete();
    repeat (10) @(negedge clk);
    chk("post_rst_fifo_empty", 32'(issued.size()), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sad_scheduler.md
# sad_scheduler

Column scheduler and result collector for the stereo SAD disparity engine. Accepts a stream of KERNEL_WIDTH-pixel left/right columns from the line buffers, buffers them in a small FIFO, and issues one column at a time to the engine only when it is idle. It collects the engine's depth results and masks warm-up columns whose right-image window is not yet populated. It emits a raster-ordered depth stream with frame-done and overflow/stall diagnostics.

## Interface
- KERNEL_WIDTH, 3, pixels per column (engine kernel width)
- OFFSET, 10, engine disparity search range
- FIFO_DEPTH, 4, column FIFO entries (power of 2, ≥2)
- H_ACTIVE, 320, columns per row
- V_ACTIVE, 240, rows per frame
- clk_in  in  1  system clock; all logic on rising edge
- rst_n_in  in  1  synchronous active-low reset
- col_valid_in  in  1  input column present
- col_ready_out  out  1  FIFO can accept (= !full, registered state)
- left_col_in / right_col_in  in  KERNEL_WIDTH×8  column pixels, [0] = top
- hcount_in  in  10  column x; vcount_in  in  9  row y
- sad_valid_out  out  1  one-cycle issue strobe to engine
- sad_left_out / sad_right_out  out  KERNEL_WIDTH×8  issued column
- sad_hcount_out  out  10; sad_vcount_out  out  9  issued coordinates
- sad_busy_in  in  1  engine busy
- sad_valid_in  in  1  engine result strobe
- sad_hcount_in  in  10; sad_vcount_in  in  9; sad_depth_in  in  8  engine result
- depth_valid_out  out  1; depth_hcount_out  out  10; depth_vcount_out  out  9; depth_out  out  8
- frame_done_out  out  1  one-cycle pulse with last pixel of frame
- drop_count_out  out  16  saturating count of columns dropped while full
- stall_err_out  out  1  sticky: engine busy exceeded timeout

## Operation
- FIFO: push when col_valid_in && col_ready_out; if col_valid_in && full, the column is dropped and drop_count_out increments (saturates at 16'hFFFF). A pop in the same cycle does not make room for a push (ready depends on registered full only).
- Issue FSM states: IDLE, ISSUE, ARM, WAIT.
  - IDLE: if FIFO non-empty && !sad_busy_in → pop head into output registers, go ISSUE.
  - ISSUE: sad_valid_out=1 with registered column/coords for exactly this cycle; go ARM.
  - ARM: one guard cycle (engine busy not yet visible); go WAIT; load timeout counter with 0.
  - WAIT: while sad_busy_in, count up; when !sad_busy_in → IDLE. If count reaches OFFSET+4, set stall_err_out and go IDLE (abandon column).
- Minimum issue interval: ISSUE+ARM+busy duration+1 IDLE cycle.
- Collector: on sad_valid_in, register result to depth_* next cycle with depth_valid_out=1. If sad_hcount_in < KERNEL_WIDTH+OFFSET-1 (warm-up), depth_out forced to 8'd0, coordinates passed unchanged.
- frame_done_out pulses in the same cycle as the depth_valid_out carrying hcount=H_ACTIVE-1, vcount=V_ACTIVE-1.
- Collector is independent of issue FSM; simultaneous result and issue both proceed.

## Timing
- Reset (rst_n_in low at edge): FSM→IDLE, FIFO empty, col_ready_out=1, sad_valid_out=0, sad_left/right/hcount/vcount_out=0, depth_valid_out=0, depth_out=0, depth_hcount/vcount_out=0, frame_done_out=0, drop_count_out=0, stall_err_out=0. Reset mid-WAIT abandons the in-flight column; its later engine result is still forwarded by the collector only if it arrives after reset is released.
- Column accepted at edge N into empty FIFO with engine idle: popped at N+1 (IDLE), sad_valid_out high during cycle N+2.
- Result latency: depth_valid_out one cycle after sad_valid_in.
- stall_err_out clears only on reset.
- Wrap: FIFO pointers are log2(FIFO_DEPTH)+1 bits; full/empty from pointer MSB compare.

## Test plan
- Single column, hcount=20, vcount=5, engine model busy 11 cycles → exactly one sad_valid_out pulse with same pixels/coords; result depth 127 → depth_out=127, hcount 20.
- Warm-up mask: results at hcount 0..11 with depth 200 → depth_out=0; hcount=12 → 200.
- Burst 6 columns back-to-back, FIFO_DEPTH=4, engine busy → col_ready_out low after 4th, 2 drops, drop_count_out=2; remaining 4 issued in order, one per busy window.
- Engine busy stuck high → stall_err_out set OFFSET+4 cycles after ARM, FSM returns IDLE, next column issued once busy drops.
- Result with hcount=319, vcount=239 → frame_done_out and depth_valid_out high same cycle; hcount=319, vcount=238 → no pulse.
- Assert rst_n_in low during WAIT → all outputs reset values next cycle, FIFO empty, col_ready_out=1.
